// File: rtl/cmp_pkg.sv
// Shared types and sizing helpers for the serial magnitude comparator.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } cmp_state_t;

  // Bits examined by the shared comparator slice each clock.
  localparam int SLICE_W = 2;

  // Number of slice evaluations needed to cover a WIDTH-bit operand.
  function automatic int calc_nslice(input int width);
    return width / SLICE_W;
  endfunction

endpackage

// File: rtl/cmp2_slice.sv
// 2-bit unsigned magnitude comparator slice built from gate primitives.
// Latency: purely combinational, zero cycles.
// Backpressure: none; exactly one of eq/gt/lt is high for any input.
module cmp2_slice (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic       eq,
  output logic       gt,
  output logic       lt
);

  wire na1, na0, nb1, nb0;
  wire x1, x0;
  wire g_hi, g_lo, l_hi, l_lo;
  wire eq_w, gt_w, lt_w;

  not u_na1 (na1, a[1]);
  not u_na0 (na0, a[0]);
  not u_nb1 (nb1, b[1]);
  not u_nb0 (nb0, b[0]);

  // Per-bit equality; the high-bit equality gates the low-bit decision.
  xnor u_x1 (x1, a[1], b[1]);
  xnor u_x0 (x0, a[0], b[0]);

  and u_ghi (g_hi, a[1], nb1);
  and u_glo (g_lo, x1, a[0], nb0);
  or  u_gt  (gt_w, g_hi, g_lo);

  and u_lhi (l_hi, na1, b[1]);
  and u_llo (l_lo, x1, na0, b[0]);
  or  u_lt  (lt_w, l_hi, l_lo);

  and u_eq  (eq_w, x1, x0);

  assign eq = eq_w;
  assign gt = gt_w;
  assign lt = lt_w;

endmodule

// File: rtl/serial_mag_cmp_ctrl.sv
// Serial WIDTH-bit unsigned comparator: one shared 2-bit slice walked MSB pair first.
// Latency: k+1 clocks from accepting edge to done, k = first differing pair (NSLICE-1 if equal).
// Backpressure: start is only accepted in IDLE or DONE; it is ignored while busy.
module serial_mag_cmp_ctrl
  import cmp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             Eq,
  output logic             Gt,
  output logic             Lt
);

  localparam int NSLICE = calc_nslice(WIDTH);
  // Keep the counter at least one bit wide so WIDTH=2 still elaborates.
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NSLICE - 1);

  cmp_state_t       state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             eq_q, eq_d;
  logic             gt_q, gt_d;
  logic             lt_q, lt_d;

  logic             sl_eq, sl_gt, sl_lt;

  // The slice always looks at the top pair; the shift registers feed it.
  cmp2_slice u_slice (
    .a  (sa_q[WIDTH-1 -: SLICE_W]),
    .b  (sb_q[WIDTH-1 -: SLICE_W]),
    .eq (sl_eq),
    .gt (sl_gt),
    .lt (sl_lt)
  );

  // Next-state, datapath and flag updates for the three-state controller.
  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    cnt_d   = cnt_q;
    eq_d    = eq_q;
    gt_d    = gt_q;
    lt_d    = lt_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          sa_d    = A;
          sb_d    = B;
          cnt_d   = CNT_LAST;
          eq_d    = 1'b0;
          gt_d    = 1'b0;
          lt_d    = 1'b0;
          state_d = CMP;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end

      CMP: begin
        if (!sl_eq) begin
          // First differing pair decides the whole compare.
          gt_d    = sl_gt;
          lt_d    = sl_lt;
          state_d = DONE;
        end else if (cnt_q == '0) begin
          eq_d    = 1'b1;
          state_d = DONE;
        end else begin
          sa_d  = sa_q << SLICE_W;
          sb_d  = sb_q << SLICE_W;
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State, shift registers, counter and flags with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      cnt_q   <= '0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      cnt_q   <= cnt_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
    end
  end

  assign busy = (state_q == CMP);
  assign done = (state_q == DONE);
  assign Eq   = eq_q;
  assign Gt   = gt_q;
  assign Lt   = lt_q;

endmodule

// File: tb/tb_serial_mag_cmp_ctrl.sv
// Self-checking bench for serial_mag_cmp_ctrl at WIDTH=8.
// Latency: observes done k+1 edges after the accepting edge.
// Backpressure: exercises start while busy and start held through done.
module tb_serial_mag_cmp_ctrl;

  localparam int W  = 8;
  localparam int NS = W / 2;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         busy;
  logic         done;
  logic         Eq;
  logic         Gt;
  logic         Lt;

  int checks;
  int errors;

  serial_mag_cmp_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .Eq    (Eq),
    .Gt    (Gt),
    .Lt    (Lt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   fl;   // {Eq,Gt,Lt}
    int           lat;  // edges from accept to done
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: flags from whole-number comparison; latency from the index of
  // the first base-4 digit (MSB first) where the operands differ.
  function automatic void ref_cmp(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [2:0] fl, output int lat);
    int ia, ib, da, db;
    ia = int'(a);
    ib = int'(b);
    if (ia == ib)     fl = 3'b100;
    else if (ia > ib) fl = 3'b010;
    else              fl = 3'b001;
    lat = NS;
    for (int i = 0; i < NS; i++) begin
      da = (ia / (4 ** (NS - 1 - i))) % 4;
      db = (ib / (4 ** (NS - 1 - i))) % 4;
      if (da != db) begin
        lat = i + 1;
        break;
      end
    end
  endfunction

  // Wait for done, counting edges after the accept edge starting at c0.
  task automatic wait_done(input int c0, output int lat, output int busy_cyc, output int bad_fl);
    lat      = -1;
    busy_cyc = 0;
    bad_fl   = 0;
    for (int c = c0; c <= c0 + 20; c++) begin
      if (done) begin
        lat = c;
        break;
      end
      if (busy) begin
        busy_cyc++;
        if ({Eq, Gt, Lt} != 3'b000) bad_fl++;
      end
      tick();
    end
  endtask

  task automatic run_cmp(input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat, output logic [2:0] fl,
                         output int busy_cyc, output int bad_fl);
    A     = a;
    B     = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    A     = W'($urandom);
    B     = W'($urandom);
    wait_done(0, lat, busy_cyc, bad_fl);
    fl = {Eq, Gt, Lt};
  endtask

  initial begin
    int         lat, bc, bf, ndone, exp_lat;
    logic [2:0] fl, exp_fl;
    logic [W-1:0] ra, rb, mask;

    checks = 0;
    errors = 0;

    vecs[0] = '{8'hA5, 8'hA5, 3'b100, 4};
    vecs[1] = '{8'hC0, 8'h3F, 3'b010, 1};
    vecs[2] = '{8'h12, 8'h13, 3'b001, 4};
    vecs[3] = '{8'hFF, 8'h00, 3'b010, 1};
    vecs[4] = '{8'h00, 8'hFF, 3'b001, 1};
    vecs[5] = '{8'h30, 8'h20, 3'b010, 2};
    vecs[6] = '{8'h08, 8'h0C, 3'b001, 3};
    vecs[7] = '{8'h00, 8'h00, 3'b100, 4};

    // Reset while idle, then release.
    rst_n = 1'b0;
    start = 1'b0;
    A     = '0;
    B     = '0;
    tick();
    tick();
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_flags", 32'({Eq, Gt, Lt}), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_flags", 32'({Eq, Gt, Lt}), 32'd0);

    // Directed vectors.
    for (int i = 0; i < 8; i++) begin
      run_cmp(vecs[i].a, vecs[i].b, lat, fl, bc, bf);
      chk($sformatf("vec%0d_flags", i), 32'(fl), 32'(vecs[i].fl));
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("vec%0d_busy_cycles", i), 32'(bc), 32'(vecs[i].lat));
      chk($sformatf("vec%0d_flags_while_busy", i), 32'(bf), 32'd0);
      tick();
      chk($sformatf("vec%0d_done_pulse", i), 32'(done), 32'd0);
      chk($sformatf("vec%0d_flags_hold", i), 32'({Eq, Gt, Lt}), 32'(vecs[i].fl));
    end

    // Back-to-back: start held high through done.
    A     = 8'h01;
    B     = 8'h00;
    start = 1'b1;
    tick();
    A = 8'h00;
    B = 8'h00;
    wait_done(0, lat, bc, bf);
    chk("b2b_first_lat", 32'(lat), 32'd4);
    chk("b2b_first_flags", 32'({Eq, Gt, Lt}), 32'b010);
    tick();
    chk("b2b_accept_busy", 32'(busy), 32'd1);
    chk("b2b_accept_done", 32'(done), 32'd0);
    chk("b2b_accept_flags", 32'({Eq, Gt, Lt}), 32'd0);
    start = 1'b0;
    wait_done(0, lat, bc, bf);
    chk("b2b_second_lat", 32'(lat), 32'd4);
    chk("b2b_second_flags", 32'({Eq, Gt, Lt}), 32'b100);
    tick();

    // start pulsed mid-compare with different operands is ignored.
    A     = 8'h12;
    B     = 8'h13;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    A     = 8'hFF;
    B     = 8'h00;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(2, lat, bc, bf);
    chk("midstart_lat", 32'(lat), 32'd4);
    chk("midstart_flags", 32'({Eq, Gt, Lt}), 32'b001);
    ndone = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (done) ndone++;
    end
    chk("midstart_extra_done", 32'(ndone), 32'd0);

    // Reset during the second compare cycle aborts without done.
    A     = 8'hA5;
    B     = 8'hA5;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_flags", 32'({Eq, Gt, Lt}), 32'd0);
    ndone = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (done || busy) ndone++;
    end
    chk("abort_no_activity", 32'(ndone), 32'd0);
    run_cmp(8'hC0, 8'h3F, lat, fl, bc, bf);
    chk("after_abort_flags", 32'(fl), 32'b010);
    chk("after_abort_lat", 32'(lat), 32'd1);
    tick();

    // Randomised pairs; a third share a random-length common prefix.
    for (int n = 0; n < 1000; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if ((n % 3) == 0) begin
        mask = W'((1 << (2 * $urandom_range(0, NS))) - 1);
        rb   = (ra & ~mask) | (rb & mask);
      end
      ref_cmp(ra, rb, exp_fl, exp_lat);
      run_cmp(ra, rb, lat, fl, bc, bf);
      chk($sformatf("rand%0d_flags a=%0h b=%0h", n, ra, rb), 32'(fl), 32'(exp_fl));
      chk($sformatf("rand%0d_lat a=%0h b=%0h", n, ra, rb), 32'(lat), 32'(exp_lat));
      if ($urandom_range(0, 1) == 0) tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
